// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: table geometry default,
//    2-bit counter encodings and the counter value loaded at reset.
// Latency: n/a (types and constants only). Backpressure: n/a.
package branch_predictor_pkg;

   localparam int INDEX_BITS_DEFAULT = 4;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,   // strongly not-taken
      CTR_WNT = 2'b01,   // weakly not-taken
      CTR_WT  = 2'b10,   // weakly taken
      CTR_ST  = 2'b11    // strongly taken
   } ctr_e;

   localparam logic [1:0] CTR_INIT_DEFAULT = CTR_WNT;

   // Sequential fetch address; wraps naturally at 32 bits.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, next-value only (no state held here).
// Latency: combinational. Backpressure: none.
// Ports: ctr_i current value, up_i 1=increment/0=decrement, ctr_o next value.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       up_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (up_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; predicts fetch PC, trains on ID-stage resolution.
// Latency: lookup and mispredict/redirect are combinational; table/counts update next edge.
// Backpressure: none; one resolution accepted every cycle res_valid is high.
// Ports: clk/rst (sync, active-high); if_pc -> pred_taken/pred_target;
//    res_* resolution inputs -> mispredict/redirect_pc; branch_count/miss_count statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         INDEX_BITS = INDEX_BITS_DEFAULT,
   parameter logic [1:0] CTR_INIT   = CTR_INIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   input  logic        res_pred_taken,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [15:0] branch_count,
   output logic [15:0] miss_count
);

   localparam int ENTRIES = 2 ** INDEX_BITS;
   localparam int TAG_W   = 32 - INDEX_BITS - 2;

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [31:0]      target_d [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [1:0]       ctr_d    [ENTRIES];

   logic [15:0] branch_count_q, branch_count_d;
   logic [15:0] miss_count_q,   miss_count_d;

   // Word-aligned PCs: bits [1:0] never participate in index or tag.
   logic [INDEX_BITS-1:0] if_idx, res_idx;
   logic [TAG_W-1:0]      if_tag, res_tag;
   logic                  if_hit, res_hit;
   logic [1:0]            ctr_sat;
   logic [1:0]            ctr_new;
   logic                  unused_pc_bits;

   assign if_idx  = if_pc[INDEX_BITS+1:2];
   assign if_tag  = if_pc[31:INDEX_BITS+2];
   assign res_idx = res_pc[INDEX_BITS+1:2];
   assign res_tag = res_pc[31:INDEX_BITS+2];
   assign unused_pc_bits = ^{if_pc[1:0], res_pc[1:0]};

   // Lookup reads the registered table only, so a same-cycle update to
   // the same index is not bypassed; it shows up on the next cycle.
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : seq_pc(if_pc);

   assign mispredict  = res_valid && (res_taken != res_pred_taken);
   assign redirect_pc = res_taken ? res_target : seq_pc(res_pc);

   assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

   sat_counter2 u_sat_counter2 (
      .ctr_i (ctr_q[res_idx]),
      .up_i  (res_taken),
      .ctr_o (ctr_sat)
   );

   // A tag miss replaces the entry and restarts its counter on the weak
   // side of the actual outcome rather than training the old history.
   assign ctr_new = res_hit ? ctr_sat : (res_taken ? CTR_WT : CTR_WNT);

   always_comb begin
      valid_d        = valid_q;
      tag_d          = tag_q;
      target_d       = target_q;
      ctr_d          = ctr_q;
      branch_count_d = branch_count_q;
      miss_count_d   = miss_count_q;
      if (res_valid) begin
         valid_d[res_idx]  = 1'b1;
         tag_d[res_idx]    = res_tag;
         target_d[res_idx] = res_target;
         ctr_d[res_idx]    = ctr_new;
         if (branch_count_q != 16'hFFFF) branch_count_d = branch_count_q + 16'd1;
         if (mispredict && (miss_count_q != 16'hFFFF)) miss_count_d = miss_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_INIT;
         end
         branch_count_q <= 16'd0;
         miss_count_q   <= 16'd0;
      end else begin
         valid_q        <= valid_d;
         ctr_q          <= ctr_d;
         branch_count_q <= branch_count_d;
         miss_count_q   <= miss_count_d;
      end
   end

   // Tag/target are not cleared by reset (valid masks them), but a
   // resolution arriving during reset is still dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

   assign branch_count = branch_count_q;
   assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic        res_pred_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [15:0] branch_count;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk            (clk),
      .rst            (rst),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .res_valid      (res_valid),
      .res_pc         (res_pc),
      .res_taken      (res_taken),
      .res_target     (res_target),
      .res_pred_taken (res_pred_taken),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .branch_count   (branch_count),
      .miss_count     (miss_count)
   );

   typedef struct {
      string       name;
      bit          cp;     // compare prediction
      logic        pt;
      logic [31:0] ptgt;
      bit          cm;     // compare mispredict (redirect only when mispredict expected)
      logic        mis;
      logic [31:0] rdr;
      bit          cc;     // compare counters
      logic [15:0] bc;
      logic [15:0] mc;
   } exp_t;

   exp_t sb_q[$];

   localparam logic [31:0] PC_A  = 32'h00400010;
   localparam logic [31:0] TGT_A = 32'h00400040;
   localparam logic [31:0] PC_B  = 32'h00800010;  // aliases PC_A's index
   localparam logic [31:0] TGT_B = 32'h00800080;
   localparam logic [31:0] PC_C  = 32'h00001000;

   task automatic push(input string nm,
                       input bit cp, input logic pt, input logic [31:0] ptgt,
                       input bit cm, input logic mis, input logic [31:0] rdr,
                       input bit cc, input logic [15:0] bc, input logic [15:0] mc);
      exp_t e;
      e.name = nm; e.cp = cp; e.pt = pt; e.ptgt = ptgt;
      e.cm = cm; e.mis = mis; e.rdr = rdr;
      e.cc = cc; e.bc = bc; e.mc = mc;
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs shortly after the rising edge.
   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rt,
                      input logic [31:0] rtgt, input logic rpt, input logic [31:0] ipc);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      res_valid      = rv;
      res_pc         = rpc;
      res_taken      = rt;
      res_target     = rtgt;
      res_pred_taken = rpt;
      if_pc          = ipc;
   endtask

   function automatic void cmp(input string nm, input string fld,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endfunction

   // Monitor: outputs are combinational, so each expectation is checked on
   // the falling edge of the cycle its stimulus was applied in.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         if (e.cp) begin
            cmp(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
            cmp(e.name, "pred_target", pred_target, e.ptgt);
         end
         if (e.cm) begin
            cmp(e.name, "mispredict", {31'd0, mispredict}, {31'd0, e.mis});
            if (e.mis) cmp(e.name, "redirect_pc", redirect_pc, e.rdr);
         end
         if (e.cc) begin
            cmp(e.name, "branch_count", {16'd0, branch_count}, {16'd0, e.bc});
            cmp(e.name, "miss_count", {16'd0, miss_count}, {16'd0, e.mc});
         end
      end
   end

   initial begin
      // Reset held with a live resolution: it must be discarded.
      rst = 1'b1; res_valid = 1'b1; res_pc = PC_A; res_taken = 1'b1;
      res_target = TGT_A; res_pred_taken = 1'b0; if_pc = PC_A;
      repeat (2) @(posedge clk);

      cyc(0, 0, 0, 0, 0, PC_A);
      push("reset", 1, 0, 32'h00400014, 1, 0, 0, 1, 16'd0, 16'd0);

      // First resolution: taken, predicted not-taken; lookup sees old entry.
      cyc(1, PC_A, 1, TGT_A, 0, PC_A);
      push("alloc", 1, 0, 32'h00400014, 1, 1, TGT_A, 1, 16'd0, 16'd0);
      cyc(0, 0, 0, 0, 0, PC_A);
      push("after_alloc", 1, 1, TGT_A, 1, 0, 0, 1, 16'd1, 16'd1);

      // Three more taken: counter 10 -> 11 -> 11 -> 11.
      repeat (3) begin
         cyc(1, PC_A, 1, TGT_A, 1, PC_A);
         push("train_t", 1, 1, TGT_A, 1, 0, 0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 0, PC_A);
      push("strong_t", 1, 1, TGT_A, 0, 0, 0, 1, 16'd4, 16'd1);

      // Not-taken once: 11 -> 10, still predicted taken.
      cyc(1, PC_A, 0, TGT_A, 1, PC_A);
      push("nt1", 1, 1, TGT_A, 1, 1, 32'h00400014, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, PC_A);
      push("weak_t", 1, 1, TGT_A, 0, 0, 0, 1, 16'd5, 16'd2);

      // Two more not-taken: 10 -> 01 -> 00.
      cyc(1, PC_A, 0, TGT_A, 1, PC_A);
      push("nt2", 1, 1, TGT_A, 1, 1, 32'h00400014, 0, 0, 0);
      cyc(1, PC_A, 0, TGT_A, 0, PC_A);
      push("nt3", 1, 0, 32'h00400014, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, PC_A);
      push("strong_nt", 1, 0, 32'h00400014, 0, 0, 0, 1, 16'd7, 16'd3);

      // Retrain to weakly taken: 00 -> 01 -> 10.
      cyc(1, PC_A, 1, TGT_A, 0, PC_A);
      push("retrain1", 0, 0, 0, 1, 1, TGT_A, 0, 0, 0);
      cyc(1, PC_A, 1, TGT_A, 0, PC_A);
      push("retrain2", 0, 0, 0, 1, 1, TGT_A, 0, 0, 0);

      // Aliasing branch replaces the entry; same-cycle lookup of PC_A sees old.
      cyc(1, PC_B, 0, TGT_B, 0, PC_A);
      push("alias_upd", 1, 1, TGT_A, 1, 0, 0, 1, 16'd9, 16'd5);
      cyc(0, 0, 0, 0, 0, PC_A);
      push("alias_miss", 1, 0, 32'h00400014, 0, 0, 0, 1, 16'd10, 16'd5);
      cyc(0, 0, 0, 0, 0, PC_B);
      push("alias_wnt", 1, 0, 32'h00800014, 0, 0, 0, 0, 0, 0);
      cyc(1, PC_B, 1, TGT_B, 0, PC_B);
      push("alias_t", 1, 0, 32'h00800014, 1, 1, TGT_B, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, PC_B);
      push("alias_wt", 1, 1, TGT_B, 0, 0, 0, 1, 16'd11, 16'd6);

      // Sequential target wraps at the top of the address space.
      cyc(0, 0, 0, 0, 0, 32'hFFFFFFFC);
      push("wrap", 1, 0, 32'h00000000, 0, 0, 0, 0, 0, 0);

      // 65540 mispredicts: both counts must saturate.
      repeat (65540) cyc(1, PC_C, 1, 32'h00002000, 0, PC_A);
      cyc(0, 0, 0, 0, 0, PC_A);
      push("saturate", 0, 0, 0, 1, 0, 0, 1, 16'hFFFF, 16'hFFFF);
      cyc(1, PC_C, 1, 32'h00002000, 0, PC_A);
      push("sat_mis", 0, 0, 0, 1, 1, 32'h00002000, 1, 16'hFFFF, 16'hFFFF);
      cyc(0, 0, 0, 0, 0, PC_A);
      push("sat_hold", 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameters SHALL be: INDEX_BITS, 4, log2 of table entries (16); CTR_INIT, 2'b01, counter value after reset (weakly not-taken).
REQ-002 Ports SHALL be, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- if_pc  input  32  fetch-stage PC to predict.
- pred_taken  output  1  predicted taken for if_pc.
- pred_target  output  32  predicted target (if_pc+4 when not predicted taken).
- res_valid  input  1  ID-stage branch (beq/bne) resolving this cycle.
- res_pc  input  32  PC of resolving branch.
- res_taken  input  1  actual outcome, driven by the ID-stage branch comparator's Take_Branch.
- res_target  input  32  computed branch target.
- res_pred_taken  input  1  prediction carried down the pipe with that branch.
- mispredict  output  1  flush IF/ID and redirect fetch.
- redirect_pc  output  32  correct next PC on mispredict.
- branch_count  output  16  resolved branches since reset.
- miss_count  output  16  mispredictions since reset.

Function
REQ-003 Table SHALL hold 2**INDEX_BITS entries, each: valid (1), tag (32-INDEX_BITS-2 bits), target (32), counter (2).
REQ-004 Index SHALL be pc[INDEX_BITS+1:2]; tag SHALL be pc[31:INDEX_BITS+2].
REQ-005 Lookup SHALL be combinational, zero latency: hit = valid && tag match.
REQ-006 pred_taken SHALL be hit && counter[1]; pred_target SHALL be stored target when pred_taken, else if_pc+4 (32-bit wrap at 32'hFFFFFFFC).
REQ-007 mispredict SHALL be combinational: res_valid && (res_taken != res_pred_taken); 0 when res_valid=0.
REQ-008 redirect_pc SHALL be res_target if res_taken, else res_pc+4; value is don't-care when mispredict=0 but SHALL be driven (no X).
REQ-009 On a rising edge with res_valid=1, the entry at res_pc's index SHALL be written: valid=1, tag=res_pc tag, target=res_target.
REQ-010 Counter update on tag hit: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
REQ-011 Counter update on miss or invalid entry (allocation/replacement): counter SHALL be 2'b10 if res_taken, else 2'b01.
REQ-012 Same-cycle lookup and update of the same index SHALL return the pre-update entry (no bypass); new value is visible the following cycle.
REQ-013 branch_count SHALL increment on each res_valid cycle; miss_count SHALL increment on each mispredict cycle; both saturate at 16'hFFFF.
REQ-014 With res_valid=0 no table or counter state SHALL change.

Reset
REQ-015 While rst=1 at a rising edge: all valid bits SHALL clear, all counters SHALL load CTR_INIT, branch_count and miss_count SHALL load 0; tag/target contents need not clear.
REQ-016 rst SHALL take priority over a simultaneous res_valid update; that update is discarded.
REQ-017 In the first cycle after reset, pred_taken SHALL be 0 and pred_target SHALL be if_pc+4 for every if_pc.

Structure
REQ-018 A shared package/header SHALL hold INDEX_BITS default, CTR_INIT, and counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-019 One sub-module, sat_counter2 (2-bit saturating up/down update, combinational next-value), SHALL be used for REQ-010.
REQ-020 Table SHALL be flop-based (no RAM macro) so reset of valid/counters is single-cycle.

Verification
REQ-021 Reset, then if_pc=32'h00400010 -> pred_taken=0, pred_target=32'h00400014, both counts 0.
REQ-022 res_valid=1, res_pc=32'h00400010, res_taken=1, res_target=32'h00400040, res_pred_taken=0 -> mispredict=1, redirect_pc=32'h00400040, next cycle lookup pred_taken=1, pred_target=32'h00400040, miss_count=1.
REQ-023 Same branch resolved taken 3 more times then not-taken once -> counter 11 then 10, pred_taken stays 1; two further not-taken -> 00, pred_taken=0.
REQ-024 Alias: branch at 32'h00400010 trained taken, then res_pc=32'h00800010 not-taken -> entry replaced, counter 01; lookup of 32'h00400010 -> pred_taken=0 (tag miss).
REQ-025 Same-cycle lookup and update of one index -> pred_taken reflects old entry; rst asserted with res_valid=1 -> no update, counts 0.
REQ-026 if_pc=32'hFFFFFFFC on miss -> pred_target=32'h00000000; 65540 mispredicts -> miss_count holds 16'hFFFF.
